// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER pipeline hazard controller: forwarding selects,
// interrupt-accept FSM states and the stall counter ceiling.
package otter_pipe_pkg;

    typedef enum logic [1:0] {
        REGFILE = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        TAKE = 2'd2,
        KILL = 2'd3
    } int_state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding mux select for one DE-stage source operand. MEM ALU results win
// over WB data; loads in MEM are never forwarded (that case stalls instead).
module fwd_sel_calc
    import otter_pipe_pkg::*;
(
    input  logic [4:0] i_rs_addr,
    input  logic       i_rs_used,
    input  logic [4:0] i_mem_rd_addr,
    input  logic       i_mem_reg_write,
    input  logic       i_mem_mem_read,
    input  logic [4:0] i_wb_rd_addr,
    input  logic       i_wb_reg_write,
    output logic [1:0] o_sel
);

    fwd_sel_t w_sel;

    always_comb begin
        w_sel = REGFILE;
        if (i_rs_used && (i_rs_addr != 5'd0)) begin
            if (i_mem_reg_write && !i_mem_mem_read && (i_rs_addr == i_mem_rd_addr)) begin
                w_sel = FWD_MEM;
            end else if (i_wb_reg_write && (i_rs_addr == i_wb_rd_addr)) begin
                w_sel = FWD_WB;
            end
        end
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// OTTER pipeline hazard control: operand forwarding, load-use stall, branch
// kill bubbles, external interrupt acceptance and a saturating stall counter.
module pipe_hazard_ctrl
    import otter_pipe_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  de_rs1_addr,
    input  logic [4:0]  de_rs2_addr,
    input  logic        de_rs1_used,
    input  logic        de_rs2_used,
    input  logic [4:0]  ex_rd_addr,
    input  logic [4:0]  mem_rd_addr,
    input  logic [4:0]  wb_rd_addr,
    input  logic        ex_reg_write,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic        ex_mem_read,
    input  logic        mem_mem_read,
    input  logic        ex_redirect,
    input  logic        intr,
    input  logic        mie,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        de_ex_bubble,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        int_taken,
    output logic [15:0] stall_count,
    output logic [1:0]  dbg_int_state
);

    int_state_t  r_state;
    int_state_t  w_state_nxt;
    logic        r_kill;
    logic [15:0] r_stall_count;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;
    logic        w_ex_load;
    logic        w_mem_load;
    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_stall;

    fwd_sel_calc u_fwd_a (
        .i_rs_addr       (de_rs1_addr),
        .i_rs_used       (de_rs1_used),
        .i_mem_rd_addr   (mem_rd_addr),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_mem_read  (mem_mem_read),
        .i_wb_rd_addr    (wb_rd_addr),
        .i_wb_reg_write  (wb_reg_write),
        .o_sel           (w_fwd_a)
    );

    fwd_sel_calc u_fwd_b (
        .i_rs_addr       (de_rs2_addr),
        .i_rs_used       (de_rs2_used),
        .i_mem_rd_addr   (mem_rd_addr),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_mem_read  (mem_mem_read),
        .i_wb_rd_addr    (wb_rd_addr),
        .i_wb_reg_write  (wb_reg_write),
        .o_sel           (w_fwd_b)
    );

    assign w_ex_load  = ex_mem_read && ex_reg_write;
    assign w_mem_load = mem_mem_read && mem_reg_write;
    assign w_rs1_hit  = de_rs1_used && (de_rs1_addr != 5'd0) &&
                        ((w_ex_load && (de_rs1_addr == ex_rd_addr)) ||
                         (w_mem_load && (de_rs1_addr == mem_rd_addr)));
    assign w_rs2_hit  = de_rs2_used && (de_rs2_addr != 5'd0) &&
                        ((w_ex_load && (de_rs2_addr == ex_rd_addr)) ||
                         (w_mem_load && (de_rs2_addr == mem_rd_addr)));
    // A redirect or interrupt accept replaces the stalled DE instruction, so
    // holding the front end would only waste a cycle.
    assign w_stall    = (w_rs1_hit || w_rs2_hit) && !ex_redirect && (r_state != TAKE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (intr && mie) w_state_nxt = PEND;
            end
            PEND: begin
                if (!mie) begin
                    w_state_nxt = RUN;
                end else if (!ex_redirect && !r_kill && !w_stall) begin
                    w_state_nxt = TAKE;
                end
            end
            TAKE:    w_state_nxt = KILL;
            KILL:    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        de_ex_bubble = 1'b0;
        int_taken    = 1'b0;
        if (RESET) begin
            de_ex_bubble = 1'b1;
        end else begin
            if (w_stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                de_ex_bubble = 1'b1;
            end
            if (ex_redirect || r_kill) de_ex_bubble = 1'b1;
            if (r_state == TAKE) begin
                int_taken    = 1'b1;
                de_ex_bubble = 1'b1;
            end
            if (r_state == KILL) de_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_kill        <= 1'b0;
            r_stall_count <= 16'd0;
        end else begin
            r_kill <= ex_redirect;
            if (w_stall && (r_stall_count != STALL_MAX)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign fwd_a_sel     = RESET ? 2'd0 : w_fwd_a;
    assign fwd_b_sel     = RESET ? 2'd0 : w_fwd_b;
    assign stall_count   = r_stall_count;
    assign dbg_int_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard/interrupt scenarios plus random
// traffic, all compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    import otter_pipe_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  de_rs1_addr, de_rs2_addr;
    logic        de_rs1_used, de_rs2_used;
    logic [4:0]  ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic        ex_reg_write, mem_reg_write, wb_reg_write;
    logic        ex_mem_read, mem_mem_read;
    logic        ex_redirect, intr, mie;
    logic        pc_write, if_id_write, de_ex_bubble, int_taken;
    logic [1:0]  fwd_a_sel, fwd_b_sel, dbg_int_state;
    logic [15:0] stall_count;

    pipe_hazard_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .ex_mem_read(ex_mem_read), .mem_mem_read(mem_mem_read),
        .ex_redirect(ex_redirect), .intr(intr), .mie(mie),
        .pc_write(pc_write), .if_id_write(if_id_write), .de_ex_bubble(de_ex_bubble),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .int_taken(int_taken),
        .stall_count(stall_count), .dbg_int_state(dbg_int_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard / model state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [25:0] exp_q[$];

    bit m_pending;     // interrupt seen, waiting for a clean slot
    int m_age;         // 0 idle, 1 accept cycle, 2 cycle after accept
    bit m_kill_prev;   // redirect happened last cycle
    int m_stalls;
    bit m_stall_now;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] a, input logic u);
        if (!u || a == 5'd0) return 2'd0;
        if (mem_reg_write && !mem_mem_read && a == mem_rd_addr) return 2'd1;
        if (wb_reg_write && a == wb_rd_addr) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit ref_load_use();
        logic [4:0] src[2];
        bit         used[2];
        src[0] = de_rs1_addr; src[1] = de_rs2_addr;
        used[0] = de_rs1_used; used[1] = de_rs2_used;
        for (int i = 0; i < 2; i++) begin
            if (used[i] && src[i] != 5'd0) begin
                if (ex_mem_read && ex_reg_write && src[i] == ex_rd_addr) return 1'b1;
                if (mem_mem_read && mem_reg_write && src[i] == mem_rd_addr) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        de_rs1_addr = 5'd0; de_rs2_addr = 5'd0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
        ex_rd_addr = 5'd0; mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
        ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        ex_mem_read = 1'b0; mem_mem_read = 1'b0;
        ex_redirect = 1'b0; intr = 1'b0; mie = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    task automatic drive_random();
        de_rs1_addr   = pick_reg();
        de_rs2_addr   = pick_reg();
        de_rs1_used   = ($urandom_range(0, 3) != 0);
        de_rs2_used   = ($urandom_range(0, 3) != 0);
        ex_rd_addr    = pick_reg();
        mem_rd_addr   = pick_reg();
        wb_rd_addr    = pick_reg();
        ex_mem_read   = ($urandom_range(0, 3) == 0);
        mem_mem_read  = ($urandom_range(0, 3) == 0);
        ex_reg_write  = ex_mem_read || ($urandom_range(0, 1) == 1);
        mem_reg_write = mem_mem_read || ($urandom_range(0, 1) == 1);
        wb_reg_write  = ($urandom_range(0, 1) == 1);
        ex_redirect   = ($urandom_range(0, 5) == 0);
        intr          = ($urandom_range(0, 7) == 0);
        mie           = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_age = 0; m_kill_prev = 1'b0; m_stalls = 0; m_stall_now = 1'b0;
        exp_q.delete();
    endtask

    // Reset asserted from posedge+1; outputs checked while it is held.
    task automatic do_reset();
        RESET = 1'b1;
        #1;
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_if_id_write", 32'(if_id_write), 32'd1);
        chk("rst_bubble", 32'(de_ex_bubble), 32'd1);
        chk("rst_int_taken", 32'(int_taken), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        chk("rst_state", 32'(dbg_int_state), 32'(RUN));
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    // Compare every output with the model at the negedge of the current cycle.
    task automatic sample();
        logic [25:0] e;
        int_state_t  es;
        bit          lu, taking, st, bub;
        @(negedge CLK);
        lu     = ref_load_use();
        taking = (m_age == 1);
        st     = lu && !ex_redirect && !taking;
        bub    = st || ex_redirect || m_kill_prev || (m_age != 0);
        es     = (m_age == 1) ? TAKE : (m_age == 2) ? KILL : m_pending ? PEND : RUN;
        exp_q.push_back({~st, ~st, bub, taking, ref_fwd(de_rs1_addr, de_rs1_used),
                         ref_fwd(de_rs2_addr, de_rs2_used), 2'(es), 16'(m_stalls)});
        m_stall_now = st;
        e = exp_q.pop_front();
        chk("pc_write", 32'(pc_write), 32'(e[25]));
        chk("if_id_write", 32'(if_id_write), 32'(e[24]));
        chk("de_ex_bubble", 32'(de_ex_bubble), 32'(e[23]));
        chk("int_taken", 32'(int_taken), 32'(e[22]));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e[21:20]));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e[19:18]));
        chk("int_state", 32'(dbg_int_state), 32'(e[17:16]));
        chk("stall_count", 32'(stall_count), 32'(e[15:0]));
    endtask

    task automatic advance();
        if (m_age == 1) begin
            m_age = 2;
        end else if (m_age == 2) begin
            m_age = 0;
        end else if (m_pending) begin
            if (!mie) begin
                m_pending = 1'b0;
            end else if (!ex_redirect && !m_kill_prev && !m_stall_now) begin
                m_pending = 1'b0;
                m_age = 1;
            end
        end else if (intr && mie) begin
            m_pending = 1'b1;
        end
        m_kill_prev = ex_redirect;
        if (m_stall_now && m_stalls < 65535) m_stalls++;
        @(posedge CLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        do_reset();

        // ALU result forwarding from MEM, and x0 never forwarded
        mem_rd_addr = 5'd5; mem_reg_write = 1'b1; de_rs1_addr = 5'd5; de_rs1_used = 1'b1;
        sample(); chk("fwd_mem_x5", 32'(fwd_a_sel), 32'd1); advance();
        mem_rd_addr = 5'd0; de_rs1_addr = 5'd0;
        sample(); chk("fwd_mem_x0", 32'(fwd_a_sel), 32'd0); advance();

        // load x7 in EX, consumer in DE: two stall cycles then WB forward
        set_idle(); do_reset();
        ex_rd_addr = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        de_rs2_addr = 5'd7; de_rs2_used = 1'b1;
        sample(); chk("lu_stall1", 32'(pc_write), 32'd0); advance();
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
        mem_rd_addr = 5'd7; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        sample(); chk("lu_stall2", 32'(pc_write), 32'd0); advance();
        mem_rd_addr = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
        wb_rd_addr = 5'd7; wb_reg_write = 1'b1;
        sample();
        chk("lu_count", 32'(stall_count), 32'd2);
        chk("lu_fwd_wb", 32'(fwd_b_sel), 32'd2);
        chk("lu_release", 32'(pc_write), 32'd1);
        advance();

        // redirect overrides a simultaneous load-use
        set_idle();
        ex_rd_addr = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        de_rs2_addr = 5'd7; de_rs2_used = 1'b1; ex_redirect = 1'b1;
        sample();
        chk("redir_pc", 32'(pc_write), 32'd1);
        chk("redir_ifid", 32'(if_id_write), 32'd1);
        chk("redir_bub0", 32'(de_ex_bubble), 32'd1);
        advance();
        set_idle();
        sample(); chk("redir_bub1", 32'(de_ex_bubble), 32'd1); advance();
        sample();
        chk("redir_bub2", 32'(de_ex_bubble), 32'd0);
        chk("redir_count", 32'(stall_count), 32'd2);
        advance();

        // interrupt raised during a redirect waits for the kill flag to clear
        set_idle(); do_reset();
        intr = 1'b1; ex_redirect = 1'b1;
        sample(); advance();
        intr = 1'b0; ex_redirect = 1'b0;
        sample(); chk("irq_pend1", 32'(dbg_int_state), 32'(PEND)); chk("irq_nt1", 32'(int_taken), 32'd0); advance();
        sample(); chk("irq_pend2", 32'(dbg_int_state), 32'(PEND)); chk("irq_nt2", 32'(int_taken), 32'd0); advance();
        sample(); chk("irq_take", 32'(int_taken), 32'd1); chk("irq_bub1", 32'(de_ex_bubble), 32'd1); advance();
        sample(); chk("irq_kill", 32'(int_taken), 32'd0); chk("irq_bub2", 32'(de_ex_bubble), 32'd1); advance();
        sample(); chk("irq_done", 32'(de_ex_bubble), 32'd0); chk("irq_run", 32'(dbg_int_state), 32'(RUN)); advance();

        // pending interrupt withdrawn by clearing mie
        set_idle();
        intr = 1'b1;
        sample(); advance();
        intr = 1'b0; mie = 1'b0;
        sample(); chk("mie_pend", 32'(dbg_int_state), 32'(PEND)); advance();
        for (int i = 0; i < 4; i++) begin
            sample(); chk("mie_no_take", 32'(int_taken), 32'd0); advance();
        end

        // reset while in TAKE discards the interrupt
        set_idle();
        ex_rd_addr = 5'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        de_rs1_addr = 5'd3; de_rs1_used = 1'b1;
        sample(); advance();
        set_idle(); intr = 1'b1;
        sample(); advance();
        intr = 1'b0;
        sample(); advance();
        mem_rd_addr = 5'd9; mem_reg_write = 1'b1; de_rs1_addr = 5'd9; de_rs1_used = 1'b1;
        chk("pre_rst_take", 32'(dbg_int_state), 32'(TAKE));
        do_reset();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            sample(); chk("post_rst_no_take", 32'(int_taken), 32'd0); advance();
        end

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                sample();
                advance();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
